// File: rtl/gate_tt_pkg.sv
// Shared types and sizing constants for the gate truth-table checker.
package gate_tt_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Settle down-counter: loads a hold count, counts down while enabled, flags zero.
module gate_tt_settle_timer
  import gate_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter next-state: load wins, otherwise decrement and saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (en && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps all four {A,B} vectors into a 2-input gate, holds each for SETTLE
// cycles, samples Y and records mismatches against the EXPECT truth table.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter logic [3:0] EXPECT = 4'b0111,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE - 1);
  localparam logic [1:0]       LAST_IDX = 2'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q,   idx_d;
  logic [2:0] err_q,   err_d;
  logic [3:0] fail_q,  fail_d;
  logic       load_s;
  logic       zero_s;

  gate_tt_settle_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .en    (state_q == WAIT),
    .value (RELOAD),
    .zero  (zero_s)
  );

  // Sweep sequencing, result accumulation and timer reload requests
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    fail_d  = fail_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT;
          idx_d   = 2'd0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          load_s  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      WAIT: begin
        if (zero_s) begin
          state_d = SAMPLE;
        end else begin
          state_d = WAIT;
        end
      end
      SAMPLE: begin
        // At most four samples per sweep, so err_count tops out at 4
        if (Y != EXPECT[idx_q]) begin
          fail_d[idx_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end else begin
          err_d = err_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          load_s  = 1'b1;
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any in-flight sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // The vector index register directly drives the gate stimulus
  assign A         = idx_q[1];
  assign B         = idx_q[0];
  assign busy      = (state_q == WAIT) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign pass      = done && (err_q == 3'd0);

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench: a selectable gate model feeds the checker; expected sweep
// results are queued at start and compared when done rises.
module tb_gate_tt_checker;

  localparam logic [3:0] EXP_DEF = 4'b0111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0;
  logic A1, B1, Y1, busy1, done1, pass1;
  logic A2, B2, Y2, busy2, done2, pass2;
  logic [2:0] err1, err2;
  logic [3:0] fail1, fail2;
  int mode = 0;
  int sel  = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] err;
    logic [3:0] fail;
    logic       pass;
  } exp_t;
  exp_t sb[$];

  logic a_m, b_m, busy_m, done_m, pass_m;
  logic [2:0] err_m;
  logic [3:0] fail_m;

  function automatic logic gate(input int m, input logic a, input logic b);
    case (m)
      0:       return ~(a & b);
      1:       return a & b;
      default: return 1'b1;
    endcase
  endfunction

  assign Y1 = gate(mode, A1, B1);
  assign Y2 = ~(A2 & B2);

  gate_tt_checker #(.EXPECT(4'b0111), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Y(Y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
  );

  gate_tt_checker #(.EXPECT(4'b0111), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2), .Y(Y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (sel == 0) begin
      a_m = A1; b_m = B1; busy_m = busy1; done_m = done1;
      pass_m = pass1; err_m = err1; fail_m = fail1;
    end else begin
      a_m = A2; b_m = B2; busy_m = busy2; done_m = done2;
      pass_m = pass2; err_m = err2; fail_m = fail2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy_m), 32'd0);
    check({tag, "_done"}, 32'(done_m), 32'd0);
    check({tag, "_pass"}, 32'(pass_m), 32'd0);
    check({tag, "_ab"},   32'({a_m, b_m}), 32'd0);
    check({tag, "_err"},  32'(err_m), 32'd0);
    check({tag, "_fail"}, 32'(fail_m), 32'd0);
  endtask

  // Runs one sweep on the selected instance; pulse_at re-pulses start mid-sweep
  task automatic run_sweep(input int settle, input int pulse_at);
    exp_t e;
    exp_t got;
    logic [1:0] v;
    logic y;
    int lat;
    e.err = 3'd0;
    e.fail = 4'd0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      y = (sel == 0) ? gate(mode, v[1], v[0]) : ~(v[1] & v[0]);
      if (y !== EXP_DEF[i]) begin
        e.fail[i] = 1'b1;
        e.err = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    sb.push_back(e);

    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    check("start_done_low", 32'(done_m), 32'd0);
    check("start_busy",     32'(busy_m), 32'd1);
    check("start_err_clr",  32'(err_m),  32'd0);
    check("start_fail_clr", 32'(fail_m), 32'd0);

    lat = 0;
    while (!done_m && lat < 200) begin
      check("ab_hold", 32'({a_m, b_m}), 32'(lat / (settle + 1)));
      check("busy_run", 32'(busy_m), 32'd1);
      if (lat == pulse_at) begin
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
      end
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), 32'(4 * (settle + 1)));

    got = sb.pop_front();
    check("err_count", 32'(err_m),  32'(got.err));
    check("fail_vec",  32'(fail_m), 32'(got.fail));
    check("pass",      32'(pass_m), 32'(got.pass));
    check("ab_last",   32'({a_m, b_m}), 32'd3);
    check("busy_done", 32'(busy_m), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    sel = 0; check_idle("rst1");
    sel = 1; check_idle("rst2");
    rst = 1'b0;
    tick();

    sel = 0;
    mode = 0; run_sweep(2, -1);
    mode = 1; run_sweep(2, -1);
    mode = 0; run_sweep(2, -1);
    mode = 2; run_sweep(2, -1);
    mode = 0; run_sweep(2, 2);
    mode = 0; run_sweep(2, 7);

    // Abort during vector 2 WAIT after two AND-gate mismatches accumulated
    mode = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (6) tick();
    check("abort_pre_err",  32'(err1), 32'd2);
    check("abort_pre_fail", 32'(fail1), 32'd3);
    check("abort_pre_ab",   32'({A1, B1}), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort");
    rst = 1'b1;
    start1 = 1'b1;
    tick();
    rst = 1'b0;
    start1 = 1'b0;
    check_idle("rst_vs_start");
    mode = 0; run_sweep(2, -1);

    sel = 1;
    run_sweep(3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
